hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates all per-stage stall and clear controls, including the stall_id/clear_id pair consumed by the ID stage, plus EX-stage operand forwarding selects.
- Sequences multi-cycle data-memory accesses with a req/gnt/rvalid FSM.
- Maintains saturating stall and flush performance counters.

Parameters:
CNT_WIDTH, 32, width of the stall/flush performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_raddr_id_i  in  5  rs1 index of the instruction in ID
rs2_raddr_id_i  in  5  rs2 index of the instruction in ID
rs1_used_id_i  in  1  ID instruction reads rs1
rs2_used_id_i  in  1  ID instruction reads rs2
jalr_id_i  in  1  ID instruction is JALR (rs1 needed in ID)
jump_decision_id_i  in  1  ID resolved an unconditional jump
rs1_raddr_ex_i  in  5  rs1 index in EX
rs2_raddr_ex_i  in  5  rs2 index in EX
rs1_used_ex_i  in  1  EX instruction reads rs1
rs2_used_ex_i  in  1  EX instruction reads rs2
regfile_waddr_ex_i  in  5  destination register in EX
regfile_we_ex_i  in  1  EX instruction writes the regfile
mem_req_ex_i  in  1  EX instruction is a memory access
mem_we_ex_i  in  1  EX memory access is a store
branch_taken_ex_i  in  1  conditional branch in EX is taken
regfile_waddr_mem_i  in  5  destination register in MEM
regfile_we_mem_i  in  1  MEM instruction writes the regfile
mem_req_mem_i  in  1  MEM instruction is a memory access
mem_we_mem_i  in  1  MEM access is a store
dmem_gnt_i  in  1  data memory accepted the request
dmem_rvalid_i  in  1  data memory read data valid
regfile_waddr_wb_i  in  5  destination register in WB
regfile_we_wb_i  in  1  WB instruction writes the regfile
stall_if_o  out  1  hold the PC
stall_id_o  out  1  hold the IF/ID register
stall_ex_o  out  1  hold the ID/EX register
stall_mem_o  out  1  hold the EX/MEM register
clear_id_o  out  1  bubble into ID
clear_ex_o  out  1  bubble into EX
clear_wb_o  out  1  bubble into WB
fwd_rs1_ex_o  out  2  00 regfile, 01 MEM result, 10 WB result
fwd_rs2_ex_o  out  2  same encoding for rs2
stall_cnt_o  out  CNT_WIDTH  cycles with stall_if_o=1
flush_cnt_o  out  CNT_WIDTH  cycles with clear_id_o=1

Behaviour:
Reset:
- While rst_n=0:
  - FSM is forced to M_IDLE and both counters to 0.
  - All stall outputs are 0; clear_id_o, clear_ex_o and clear_wb_o are 1; fwd outputs are 00.

Register match definition:
- match(a,b) requires a==b, a!=0, the writer's we=1 and the reader's used=1.
- x0 never matches, never forwards and never stalls.

Memory FSM (states M_IDLE, M_REQ, M_RESP):
- M_IDLE:
  - mem_req_mem_i & dmem_gnt_i & mem_we_mem_i: store completes, stay M_IDLE, no stall.
  - mem_req_mem_i & dmem_gnt_i & ~mem_we_mem_i: go to M_RESP.
  - mem_req_mem_i & ~dmem_gnt_i: go to M_REQ.
- M_REQ:
  - gnt & store: go to M_IDLE.
  - gnt & load: go to M_RESP.
  - otherwise stay.
- M_RESP:
  - dmem_rvalid_i: go to M_IDLE.
  - otherwise stay.
- mem_busy = (M_IDLE & req & ~(gnt & we)) | (M_REQ & ~(gnt & we)) | (M_RESP & ~rvalid).
- A load therefore costs at least 1 stall cycle. The rvalid cycle itself is not stalled, so the load advances to WB with its data.

Priority (highest first), evaluated combinationally each cycle:
1. mem_busy:
   - stall_if, stall_id, stall_ex, stall_mem = 1; clear_wb = 1; clear_id = clear_ex = 0.
   - Branch/jump flushes are deferred. branch_taken_ex_i stays asserted because EX is held, so the flush applies in the release cycle.
2. branch_taken_ex_i:
   - clear_id = clear_ex = 1; no stall.
   - Overrides load-use and jump, because the ID instruction is on the wrong path.
3. Load-use hazard:
   - Condition: mem_req_ex_i & ~mem_we_ex_i & match(regfile_waddr_ex_i, rs1_id or rs2_id).
   - Response: stall_if = stall_id = 1, clear_ex = 1 for that cycle. jump_decision_id_i is ignored.
4. JALR hazard:
   - Condition: jalr_id_i & (match(waddr_ex, rs1_id) | match(waddr_mem, rs1_id)).
   - Response: same as load-use.
5. jump_decision_id_i:
   - clear_id = 1 only.

Invariants:
- A stage never sees stall and clear asserted together.
- clear_wb_o is 0 whenever mem_busy is 0 and rst_n is high.

Forwarding (combinational, independent of stalls):
- fwd_rs1_ex_o = 01 if match(waddr_mem, rs1_ex); else 10 if match(waddr_wb, rs1_ex); else 00. MEM beats WB.
- fwd_rs2_ex_o uses the same rule with rs2_ex.
- The ID stage does not use WB-to-ID bypass; the regfile is write-through.

Counters:
- stall_cnt_o increments on each clock edge where stall_if_o=1.
- flush_cnt_o increments on each clock edge where clear_id_o=1.
- Both saturate at all-ones and clear only on reset.

Reset mid-operation:
- Asserting rst_n=0 in M_REQ or M_RESP returns the FSM to M_IDLE immediately.
- A late dmem_rvalid_i seen in M_IDLE after reset is ignored.

Test Plan:
- Load x5 in EX, ID add x6,x5,x1, gnt same cycle, rvalid next -> cycle1: stall_if/id=1, clear_ex=1; next: load in MEM, M_IDLE→M_RESP, stall_mem=1, clear_wb=1; rvalid cycle: all stalls 0; stall_cnt_o=2.
- Store in MEM, gnt delayed 3 cycles -> FSM M_IDLE→M_REQ (3 cycles stalled), stalls released in the gnt cycle, stall_cnt_o=3, FSM back in M_IDLE.
- Branch taken in EX coincident with load-use in ID -> clear_id=clear_ex=1, stall_if=0, flush_cnt_o+1.
- Branch taken in EX while M_RESP waiting 2 cycles -> clears held at 0 for 2 cycles, clear_id=clear_ex=1 in the rvalid cycle.
- rs1_ex=x7 written by both MEM and WB -> fwd_rs1_ex_o=01; same test with rs1_ex=x0 and writers to x0 -> 00, no stall.
- Reset asserted in M_RESP, then rvalid pulse after release -> all stalls 0, clears 1 during reset, FSM M_IDLE, counters 0, no spurious stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/clear/forwarding control and data-memory access sequencing
module hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1_raddr_id_i,
  input  logic [4:0]           rs2_raddr_id_i,
  input  logic                 rs1_used_id_i,
  input  logic                 rs2_used_id_i,
  input  logic                 jalr_id_i,
  input  logic                 jump_decision_id_i,
  input  logic [4:0]           rs1_raddr_ex_i,
  input  logic [4:0]           rs2_raddr_ex_i,
  input  logic                 rs1_used_ex_i,
  input  logic                 rs2_used_ex_i,
  input  logic [4:0]           regfile_waddr_ex_i,
  input  logic                 regfile_we_ex_i,
  input  logic                 mem_req_ex_i,
  input  logic                 mem_we_ex_i,
  input  logic                 branch_taken_ex_i,
  input  logic [4:0]           regfile_waddr_mem_i,
  input  logic                 regfile_we_mem_i,
  input  logic                 mem_req_mem_i,
  input  logic                 mem_we_mem_i,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [4:0]           regfile_waddr_wb_i,
  input  logic                 regfile_we_wb_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 stall_ex_o,
  output logic                 stall_mem_o,
  output logic                 clear_id_o,
  output logic                 clear_ex_o,
  output logic                 clear_wb_o,
  output logic [1:0]           fwd_rs1_ex_o,
  output logic [1:0]           fwd_rs2_ex_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_RESP} mstate_e;
  mstate_e state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mem_busy, lu_haz, jalr_haz, hold, flush;
  function automatic logic match(input logic [4:0] a, input logic [4:0] b,
                                 input logic we, input logic used);
    return (a == b) && (a != 5'd0) && we && used;
  endfunction
  // next memory-access state: loads wait for rvalid, stores finish on grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: if (mem_req_mem_i) state_d = dmem_gnt_i ? (mem_we_mem_i ? M_IDLE : M_RESP) : M_REQ;
      M_REQ:  if (dmem_gnt_i) state_d = mem_we_mem_i ? M_IDLE : M_RESP;
      M_RESP: if (dmem_rvalid_i) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end
  // hazard detection and prioritised stall/clear generation; reset forces bubbles everywhere
  always_comb begin
    mem_busy = ((state_q == M_IDLE) && mem_req_mem_i && !(dmem_gnt_i && mem_we_mem_i)) ||
               ((state_q == M_REQ) && !(dmem_gnt_i && mem_we_mem_i)) ||
               ((state_q == M_RESP) && !dmem_rvalid_i);
    lu_haz   = mem_req_ex_i && !mem_we_ex_i &&
               (match(regfile_waddr_ex_i, rs1_raddr_id_i, regfile_we_ex_i, rs1_used_id_i) ||
                match(regfile_waddr_ex_i, rs2_raddr_id_i, regfile_we_ex_i, rs2_used_id_i));
    jalr_haz = jalr_id_i &&
               (match(regfile_waddr_ex_i, rs1_raddr_id_i, regfile_we_ex_i, rs1_used_id_i) ||
                match(regfile_waddr_mem_i, rs1_raddr_id_i, regfile_we_mem_i, rs1_used_id_i));
    flush    = !mem_busy && branch_taken_ex_i;
    hold     = !mem_busy && !branch_taken_ex_i && (lu_haz || jalr_haz);
    stall_if_o  = rst_n && (mem_busy || hold);
    stall_id_o  = rst_n && (mem_busy || hold);
    stall_ex_o  = rst_n && mem_busy;
    stall_mem_o = rst_n && mem_busy;
    clear_id_o  = !rst_n || flush ||
                  (!mem_busy && !branch_taken_ex_i && !lu_haz && !jalr_haz && jump_decision_id_i);
    clear_ex_o  = !rst_n || flush || hold;
    clear_wb_o  = !rst_n || mem_busy;
    fwd_rs1_ex_o = !rst_n ? 2'b00 :
                   match(regfile_waddr_mem_i, rs1_raddr_ex_i, regfile_we_mem_i, rs1_used_ex_i) ? 2'b01 :
                   match(regfile_waddr_wb_i, rs1_raddr_ex_i, regfile_we_wb_i, rs1_used_ex_i) ? 2'b10 : 2'b00;
    fwd_rs2_ex_o = !rst_n ? 2'b00 :
                   match(regfile_waddr_mem_i, rs2_raddr_ex_i, regfile_we_mem_i, rs2_used_ex_i) ? 2'b01 :
                   match(regfile_waddr_wb_i, rs2_raddr_ex_i, regfile_we_wb_i, rs2_used_ex_i) ? 2'b10 : 2'b00;
  end
  // saturating performance counters
  always_comb begin
    stall_cnt_d = (stall_if_o && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (clear_id_o && rst_n && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= M_IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall/clear priority, memory sequencing, forwarding and counters
module tb_hazard_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, waddr_ex, waddr_mem, waddr_wb;
  logic rs1_used_id, rs2_used_id, jalr, jump, rs1_used_ex, rs2_used_ex;
  logic we_ex, mreq_ex, mwe_ex, branch, we_mem, mreq_mem, mwe_mem, gnt, rvalid, we_wb;
  logic stall_if, stall_id, stall_ex, stall_mem, clear_id, clear_ex, clear_wb;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [W-1:0] stall_cnt, flush_cnt;
  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_raddr_id_i(rs1_id), .rs2_raddr_id_i(rs2_id),
    .rs1_used_id_i(rs1_used_id), .rs2_used_id_i(rs2_used_id),
    .jalr_id_i(jalr), .jump_decision_id_i(jump),
    .rs1_raddr_ex_i(rs1_ex), .rs2_raddr_ex_i(rs2_ex),
    .rs1_used_ex_i(rs1_used_ex), .rs2_used_ex_i(rs2_used_ex),
    .regfile_waddr_ex_i(waddr_ex), .regfile_we_ex_i(we_ex),
    .mem_req_ex_i(mreq_ex), .mem_we_ex_i(mwe_ex), .branch_taken_ex_i(branch),
    .regfile_waddr_mem_i(waddr_mem), .regfile_we_mem_i(we_mem),
    .mem_req_mem_i(mreq_mem), .mem_we_mem_i(mwe_mem),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .regfile_waddr_wb_i(waddr_wb), .regfile_we_wb_i(we_wb),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex), .stall_mem_o(stall_mem),
    .clear_id_o(clear_id), .clear_ex_o(clear_ex), .clear_wb_o(clear_wb),
    .fwd_rs1_ex_o(fwd_rs1), .fwd_rs2_ex_o(fwd_rs2),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0; waddr_ex = 0; waddr_mem = 0; waddr_wb = 0;
    rs1_used_id = 0; rs2_used_id = 0; jalr = 0; jump = 0; rs1_used_ex = 0; rs2_used_ex = 0;
    we_ex = 0; mreq_ex = 0; mwe_ex = 0; branch = 0; we_mem = 0; mreq_mem = 0; mwe_mem = 0;
    gnt = 0; rvalid = 0; we_wb = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    rs1_ex = 5'd7; rs1_used_ex = 1; waddr_mem = 5'd7; we_mem = 1; mreq_mem = 1;
    #3;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_stall_mem", stall_mem, 0);
    chk("rst_clear_id", clear_id, 1);
    chk("rst_clear_ex", clear_ex, 1);
    chk("rst_clear_wb", clear_wb, 1);
    chk("rst_fwd_rs1", fwd_rs1, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    tick();

    // load x5 in EX, add x6,x5,x1 in ID
    reset_dut();
    mreq_ex = 1; we_ex = 1; waddr_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1; rs2_id = 5'd1; rs2_used_id = 1;
    #1;
    chk("lu_stall_if", stall_if, 1);
    chk("lu_stall_id", stall_id, 1);
    chk("lu_clear_ex", clear_ex, 1);
    chk("lu_stall_ex", stall_ex, 0);
    chk("lu_clear_id", clear_id, 0);
    tick();
    mreq_ex = 0; we_ex = 0; waddr_ex = 0;
    mreq_mem = 1; we_mem = 1; waddr_mem = 5'd5; gnt = 1;
    #1;
    chk("ld_gnt_stall_mem", stall_mem, 1);
    chk("ld_gnt_stall_if", stall_if, 1);
    chk("ld_gnt_clear_wb", clear_wb, 1);
    chk("ld_gnt_clear_ex", clear_ex, 0);
    tick();
    gnt = 0; rvalid = 1;
    #1;
    chk("ld_rvalid_stall_if", stall_if, 0);
    chk("ld_rvalid_stall_mem", stall_mem, 0);
    chk("ld_rvalid_clear_wb", clear_wb, 0);
    tick();
    idle_inputs();
    #1;
    chk("ld_stall_cnt", stall_cnt, 2);
    chk("ld_idle_stall_if", stall_if, 0);

    // store with grant delayed 3 cycles
    reset_dut();
    mreq_mem = 1; mwe_mem = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_wait_stall_mem", stall_mem, 1);
      tick();
    end
    gnt = 1;
    #1;
    chk("st_gnt_stall_if", stall_if, 0);
    tick();
    chk("st_stall_cnt", stall_cnt, 3);
    chk("st_back_idle_stall_if", stall_if, 0);
    tick();
    chk("st_stall_cnt_hold", stall_cnt, 3);

    // branch taken coincident with load-use
    reset_dut();
    branch = 1; mreq_ex = 1; we_ex = 1; waddr_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1;
    #1;
    chk("br_lu_clear_id", clear_id, 1);
    chk("br_lu_clear_ex", clear_ex, 1);
    chk("br_lu_stall_if", stall_if, 0);
    chk("br_lu_stall_id", stall_id, 0);
    tick();
    chk("br_lu_flush_cnt", flush_cnt, 1);

    // branch deferred while a load waits for rvalid
    reset_dut();
    branch = 1; mreq_mem = 1; gnt = 1;
    #1;
    chk("br_busy_clear_id", clear_id, 0);
    chk("br_busy_stall_if", stall_if, 1);
    tick();
    gnt = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("br_resp_clear_id", clear_id, 0);
      chk("br_resp_clear_ex", clear_ex, 0);
      tick();
    end
    rvalid = 1;
    #1;
    chk("br_rel_clear_id", clear_id, 1);
    chk("br_rel_clear_ex", clear_ex, 1);
    chk("br_rel_stall_if", stall_if, 0);
    tick();
    chk("br_rel_stall_cnt", stall_cnt, 3);
    chk("br_rel_flush_cnt", flush_cnt, 1);

    // forwarding, x0, JALR and jump
    reset_dut();
    rs1_ex = 5'd7; rs1_used_ex = 1; waddr_mem = 5'd7; we_mem = 1; waddr_wb = 5'd7; we_wb = 1;
    #1; chk("fwd_mem_beats_wb", fwd_rs1, 2'b01);
    we_mem = 0;
    #1; chk("fwd_wb", fwd_rs1, 2'b10);
    rs1_used_ex = 0;
    #1; chk("fwd_unused", fwd_rs1, 2'b00);
    rs2_ex = 5'd9; rs2_used_ex = 1; waddr_wb = 5'd9;
    #1; chk("fwd_rs2_wb", fwd_rs2, 2'b10);
    idle_inputs();
    rs1_ex = 0; rs1_used_ex = 1; waddr_mem = 0; we_mem = 1; waddr_wb = 0; we_wb = 1;
    mreq_ex = 1; we_ex = 1; waddr_ex = 0; rs1_id = 0; rs1_used_id = 1;
    #1;
    chk("x0_fwd", fwd_rs1, 2'b00);
    chk("x0_stall_if", stall_if, 0);
    chk("x0_clear_ex", clear_ex, 0);
    idle_inputs();
    jalr = 1; rs1_id = 5'd3; rs1_used_id = 1; waddr_mem = 5'd3; we_mem = 1;
    #1;
    chk("jalr_stall_if", stall_if, 1);
    chk("jalr_clear_ex", clear_ex, 1);
    chk("jalr_clear_id", clear_id, 0);
    idle_inputs();
    jump = 1; mreq_ex = 1; we_ex = 1; waddr_ex = 5'd4; rs2_id = 5'd4; rs2_used_id = 1;
    #1;
    chk("jump_lu_clear_id", clear_id, 0);
    chk("jump_lu_stall_id", stall_id, 1);
    mreq_ex = 0;
    #1;
    chk("jump_clear_id", clear_id, 1);
    chk("jump_clear_ex", clear_ex, 0);
    chk("jump_stall_if", stall_if, 0);
    idle_inputs();

    // reset while waiting for read data
    reset_dut();
    mreq_mem = 1; gnt = 1;
    tick();
    gnt = 0;
    #1;
    chk("resp_wait_stall_if", stall_if, 1);
    rst_n = 1'b0;
    rs1_ex = 5'd7; rs1_used_ex = 1; waddr_mem = 5'd7; we_mem = 1;
    #1;
    chk("midrst_stall_if", stall_if, 0);
    chk("midrst_clear_id", clear_id, 1);
    chk("midrst_clear_wb", clear_wb, 1);
    chk("midrst_fwd", fwd_rs1, 0);
    chk("midrst_stall_cnt", stall_cnt, 0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    rvalid = 1;
    #1;
    chk("late_rvalid_stall_if", stall_if, 0);
    tick();
    rvalid = 0;
    chk("late_rvalid_stall_cnt", stall_cnt, 0);
    mreq_mem = 1; mwe_mem = 1; gnt = 1;
    #1;
    chk("after_rst_idle_store", stall_if, 0);

    // counter saturation
    reset_dut();
    mreq_mem = 1; mwe_mem = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_cnt_sat", stall_cnt, 15);
    chk("flush_cnt_still0", flush_cnt, 0);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
